// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared pipeline constants and free-list op decode type
package free_list_pkg;

    localparam int PL_NUM_PR   = 64;
    localparam int PL_NUM_ARCH = 32;
    localparam int PL_PR_W     = 6;
    localparam int PL_DEPTH    = PL_NUM_PR - PL_NUM_ARCH;

    // Per-cycle decision of which list operations take effect.
    typedef struct packed {
        logic pop;
        logic push;
        logic restore;
        logic err;
    } fl_ops_t;

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list with retire push and recovery restore
module free_list
    import free_list_pkg::*;
#(
    parameter int NUM_PR   = PL_NUM_PR,
    parameter int NUM_ARCH = PL_NUM_ARCH,
    parameter int PR_W     = PL_PR_W,
    parameter int DEPTH    = NUM_PR - NUM_ARCH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    output logic [PR_W-1:0] PR_new,
    input  logic            retire_reg,
    input  logic [PR_W-1:0] PR_old_RT,
    input  logic            old_valid_RT,
    input  logic            recover,
    input  logic            RegDest_out,
    input  logic [PR_W-1:0] PR_new_flush,
    output logic            empty,
    output logic            full,
    output logic [PR_W-1:0] free_count,
    output logic            fl_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PR_W-1:0]  entry [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_inc;
    logic [PTR_W-1:0] head_dec;
    logic [PTR_W-1:0] tail_inc;
    logic [PR_W-1:0]  count;
    logic [PR_W-1:0]  count_next;
    logic [PR_W:0]    count_after_push;
    logic             ret_pend;
    logic             err;
    logic             pop_req;
    logic             push_req;
    logic             rest_req;
    fl_ops_t          ops;

    // Wrap explicitly so a non-power-of-two DEPTH still behaves as a ring.
    assign head_inc = (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign head_dec = (head == '0) ? PTR_W'(DEPTH - 1) : head - 1'b1;
    assign tail_inc = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;

    assign pop_req  = alloc && !recover;
    assign push_req = ret_pend && old_valid_RT;
    assign rest_req = recover && RegDest_out;

    always_comb begin
        ops              = '0;
        ops.pop          = pop_req && !empty;
        ops.push         = push_req && !full;
        count_after_push = {1'b0, count} + (PR_W+1)'(ops.push);
        // A restore must still fit after a same-cycle retire push.
        ops.restore      = rest_req && (count_after_push < (PR_W+1)'(DEPTH));
        ops.err          = (pop_req && empty)
                        || (alloc && recover)
                        || (push_req && full)
                        || (rest_req && !ops.restore);
        count_next       = count + PR_W'(ops.push) + PR_W'(ops.restore) - PR_W'(ops.pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= PR_W'(NUM_ARCH + i);
            end
            head     <= '0;
            tail     <= '0;
            count    <= PR_W'(DEPTH);
            ret_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            ret_pend <= retire_reg;
            if (ops.push) begin
                entry[tail] <= PR_old_RT;
                tail        <= tail_inc;
            end
            // Pop and restore are exclusive: pop is blocked while recover is high.
            if (ops.pop) begin
                head <= head_inc;
            end else if (ops.restore) begin
                entry[head_dec] <= PR_new_flush;
                head            <= head_dec;
            end
            count <= count_next;
            if (ops.err) begin
                err <= 1'b1;
            end
        end
    end

    assign PR_new     = entry[head];
    assign free_count = count;
    assign empty      = (count == '0);
    assign full       = (count == PR_W'(DEPTH));
    assign fl_err     = err;

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard testbench for free_list
module tb_free_list;
    import free_list_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               alloc;
    logic [PL_PR_W-1:0] PR_new;
    logic               retire_reg;
    logic [PL_PR_W-1:0] PR_old_RT;
    logic               old_valid_RT;
    logic               recover;
    logic               RegDest_out;
    logic [PL_PR_W-1:0] PR_new_flush;
    logic               empty;
    logic               full;
    logic [PL_PR_W-1:0] free_count;
    logic               fl_err;

    int vectors     = 0;
    int miscompares = 0;

    int mq[$];
    bit m_pend;
    bit m_err;

    free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc        (alloc),
        .PR_new       (PR_new),
        .retire_reg   (retire_reg),
        .PR_old_RT    (PR_old_RT),
        .old_valid_RT (old_valid_RT),
        .recover      (recover),
        .RegDest_out  (RegDest_out),
        .PR_new_flush (PR_new_flush),
        .empty        (empty),
        .full         (full),
        .free_count   (free_count),
        .fl_err       (fl_err)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        expect_eq({tag, " free_count"}, free_count, mq.size());
        expect_eq({tag, " empty"}, empty, mq.size() == 0);
        expect_eq({tag, " full"}, full, mq.size() == PL_DEPTH);
        expect_eq({tag, " fl_err"}, fl_err, m_err);
        if (mq.size() > 0) expect_eq({tag, " head"}, PR_new, mq[0]);
    endtask

    task automatic do_reset(input bit ov, input int pold, input bit rc, input bit rd);
        rst = 1'b1; alloc = 1'b0; retire_reg = 1'b0;
        old_valid_RT = ov; PR_old_RT = pold[PL_PR_W-1:0];
        recover = rc; RegDest_out = rd; PR_new_flush = 6'd1;
        @(posedge clk); #1;
        rst = 1'b0; old_valid_RT = 1'b0; recover = 1'b0; RegDest_out = 1'b0;
        mq.delete();
        for (int i = 0; i < PL_DEPTH; i++) mq.push_back(PL_NUM_ARCH + i);
        m_pend = 1'b0;
        m_err  = 1'b0;
        check_state("reset");
        expect_eq("reset PR_new", PR_new, 32);
    endtask

    task automatic step(input bit a, input bit rr, input bit ov, input int pold,
                        input bit rc, input bit rd, input int pf, input string tag);
        bit pop_ok, push_req, push_ok, rest_req, rest_ok;
        int exp_pr;
        alloc = a; retire_reg = rr; old_valid_RT = ov; PR_old_RT = pold[PL_PR_W-1:0];
        recover = rc; RegDest_out = rd; PR_new_flush = pf[PL_PR_W-1:0];
        #1;
        pop_ok   = a && !rc && mq.size() > 0;
        push_req = m_pend && ov;
        push_ok  = push_req && mq.size() < PL_DEPTH;
        rest_req = rc && rd;
        rest_ok  = rest_req && (mq.size() + int'(push_ok)) < PL_DEPTH;
        if ((a && !rc && mq.size() == 0) || (a && rc) || (push_req && !push_ok) || (rest_req && !rest_ok))
            m_err = 1'b1;
        if (pop_ok) begin
            exp_pr = mq.pop_front();
            expect_eq({tag, " alloc PR_new"}, PR_new, exp_pr);
        end
        @(posedge clk); #1;
        if (push_ok) mq.push_back(pold);
        if (rest_ok) mq.push_front(pf);
        m_pend = rr;
        check_state(tag);
    endtask

    initial begin
        rst = 1'b1; alloc = 1'b0; retire_reg = 1'b0; PR_old_RT = '0; old_valid_RT = 1'b0;
        recover = 1'b0; RegDest_out = 1'b0; PR_new_flush = '0;
        do_reset(1'b0, 0, 1'b0, 1'b0);

        repeat (3) step(1, 0, 0, 0, 0, 0, 0, "alloc3");
        expect_eq("after3 PR_new", PR_new, 35);
        expect_eq("after3 count", free_count, 29);

        step(0, 1, 0, 0, 0, 0, 0, "ret_n");
        step(0, 0, 1, 7, 0, 0, 0, "ret_n1");
        expect_eq("retire count", free_count, 30);
        step(0, 1, 0, 0, 0, 0, 0, "ret_inv_n");
        step(0, 0, 0, 9, 0, 0, 0, "ret_inv_n1");
        step(0, 0, 1, 11, 0, 0, 0, "ov_no_pend");
        expect_eq("no push count", free_count, 30);

        repeat (30) step(1, 0, 0, 0, 0, 0, 0, "drain");
        expect_eq("drained empty", empty, 1);
        step(1, 0, 0, 0, 0, 0, 0, "underflow");
        expect_eq("underflow err", fl_err, 1);
        step(0, 1, 0, 0, 0, 0, 0, "refill_n");
        step(0, 0, 1, 20, 0, 0, 0, "refill_n1");
        expect_eq("refill head", PR_new, 20);

        do_reset(1'b0, 0, 1'b0, 1'b0);
        repeat (8) step(1, 0, 0, 0, 0, 0, 0, "pre40");
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, "a404142");
        step(0, 0, 0, 0, 1, 1, 42, "rec42");
        step(0, 0, 0, 0, 1, 1, 41, "rec41");
        expect_eq("recover PR_new", PR_new, 41);
        expect_eq("recover count", free_count, 23);
        expect_eq("recover no err", fl_err, 0);
        step(1, 0, 0, 0, 1, 0, 0, "alloc_in_rec");
        expect_eq("alloc_in_rec err", fl_err, 1);

        do_reset(1'b0, 0, 1'b0, 1'b0);
        repeat (22) step(1, 0, 0, 0, 0, 0, 0, "to10");
        step(0, 1, 0, 0, 0, 0, 0, "pp_arm");
        for (int i = 0; i < 40; i++) step(1, 1, 1, (i * 7 + 3) % 64, 0, 0, 0, "pushpop");
        expect_eq("pushpop count", free_count, 10);
        step(0, 0, 1, 33, 1, 1, 50, "push_rest");
        expect_eq("push_rest count", free_count, 12);

        do_reset(1'b0, 0, 1'b0, 1'b0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, "pre_rst");
        step(0, 1, 0, 0, 1, 1, 33, "rec_pend");
        do_reset(1'b1, 9, 1'b1, 1'b1);
        step(0, 0, 1, 9, 0, 0, 0, "stray");
        expect_eq("stray count", free_count, 32);
        step(0, 1, 0, 0, 0, 0, 0, "ovf_n");
        step(0, 0, 1, 9, 0, 0, 0, "ovf_n1");
        expect_eq("overflow err", fl_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the out-of-order pipe. It hands a free PR# to dispatch for every instruction that writes a register, and takes back the retired instruction's previous PR# from the reorder buffer's retire port. During branch/jump recovery it re-absorbs the PR_new of each instruction the reorder buffer walks back from its tail. It sits between the reorder buffer's retire/flush outputs and the dispatch stage, beside the map table.

## Interface
Parameters:
- NUM_PR, 64, total physical registers.
- NUM_ARCH, 32, architectural registers. PRs 0..NUM_ARCH-1 are mapped at reset.
- PR_W, 6, PR# width.
- DEPTH, NUM_PR-NUM_ARCH = 32, free-list capacity.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- alloc  in  1  dispatch consumes PR_new this cycle (isDispatch && RegDest && !hazard_stall).
- PR_new  out  PR_W  PR# at head of list; valid when !empty.
- retire_reg  in  1  ROB head retires this cycle (qualified read).
- PR_old_RT  in  PR_W  retired PR_old; valid the cycle after retire_reg.
- old_valid_RT  in  1  retired entry had a valid PR_old; sampled with PR_old_RT.
- recover  in  1  ROB recovery walk active.
- RegDest_out  in  1  flushed entry wrote a register.
- PR_new_flush  in  PR_W  flushed entry's PR_new.
- empty  out  1  free_count == 0.
- full  out  1  free_count == DEPTH.
- free_count  out  PR_W  number of free PRs, 0..DEPTH.
- fl_err  out  1  sticky protocol error: pop when empty, push when full, or alloc during recover.

## Operation
- Storage: DEPTH x PR_W circular array, plus head (pop pointer, log2 DEPTH bits), tail (push pointer), and free_count. All pointers wrap modulo DEPTH.
- Reset: entry[i] = NUM_ARCH+i, head=0, tail=0, free_count=DEPTH, full=1, empty=0, fl_err=0, ret_pend=0.
- Pop (alloc && !recover && !empty): head <= head+1, free_count -1. PR_new = entry[head], combinational.
- Retire push: ret_pend <= retire_reg each cycle. In the next cycle, if ret_pend && old_valid_RT: entry[tail] <= PR_old_RT, tail <= tail+1, free_count +1.
- Recovery restore (recover && RegDest_out): entry[head-1] <= PR_new_flush, head <= head-1, free_count +1. The PR is written explicitly because the slot may have been reused.
- While recover is high, alloc is ignored. If alloc is high during recover, fl_err is set.
- Simultaneous push and pop: both pointers advance and free_count is unchanged.
- Simultaneous push and restore: both apply and free_count increases by 2.
- Simultaneous pop and push when empty: the pop is refused (empty has priority) and the push proceeds.
- Error cases: pop when empty or push/restore when full sets fl_err and is otherwise dropped. Pointers and count are untouched by the dropped operation. fl_err clears only on rst.
- Reset mid-recovery or with ret_pend set restores the reset state exactly. The pending push is discarded.

## Timing
- PR_new: zero latency from head; it updates the cycle after a pop or restore.
- Retire: retire_reg in cycle N. PR_old_RT and old_valid_RT are sampled in N+1. The PR is visible in entry[tail] and counted from N+2.
- Restore: one PR per recover cycle. It is visible as PR_new in the following cycle.
- empty, full and free_count are registered-derived and reflect updates from the previous edge.

## Structure
- NUM_PR, NUM_ARCH and PR_W go in the shared pipeline constants header, also used by the map table, reorder buffer and RS.
- No sub-module. Array, pointers, counter and ret_pend live in one always block for state, plus continuous assigns for outputs.

## Test plan
- Reset -> free_count=32, full=1, PR_new=32. After 3 allocs: PR_new=35, free_count=29.
- 32 consecutive allocs -> empty=1. A 33rd alloc -> fl_err=1, head unchanged.
- retire_reg in cycle N with PR_old_RT=7 and old_valid_RT=1 in N+1 -> free_count +1 at N+2. That PR is popped after the existing entries. With old_valid_RT=0 -> no change.
- Alloc 40, 41, 42, then recover 2 cycles with RegDest_out=1, PR_new_flush=42 then 41 -> PR_new=41 after recovery, free_count restored by 2. Alloc during recover -> fl_err.
- Same-cycle alloc plus retire push at free_count=10 -> free_count stays 10 and both pointers advance. Wrap-around across entry 31->0 preserves order.
- rst asserted mid-recovery with ret_pend=1 -> next cycle state equals the reset state, with no stray push.
